// File: rtl/diff_motion_detect.sv
// Motion detector on a stream of signed 8-bit differences: magnitude, confirm/hold FSM,
// onset pulse and event counter, and a clearable peak register.
module diff_motion_detect #(
    parameter int unsigned CONFIRM_CNT = 3,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] diff_in,
    input  logic       diff_valid,
    input  logic [7:0] thr_on,
    input  logic [7:0] thr_off,
    input  logic       peak_clr,
    output logic [7:0] mag_out,
    output logic       mag_valid,
    output logic       active,
    output logic       onset,
    output logic [7:0] peak,
    output logic [7:0] event_cnt,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0]  CONFIRM_N = 4'(CONFIRM_CNT);
    localparam logic [15:0] HOLD_N    = 16'(HOLD_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  confirm_q, confirm_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  mag_out_q, mag_out_d;
    logic        mag_valid_q;
    logic        active_q, active_d;
    logic        onset_q, onset_d;
    logic [7:0]  peak_q, peak_d;
    logic [7:0]  event_q, event_d;

    logic [7:0]  mag;
    logic [7:0]  eff_off;
    logic [3:0]  confirm_inc;
    logic        over, under;

    // 0x80 maps to 128, which still fits the unsigned 8-bit result.
    always_comb begin
        mag         = diff_in[7] ? (~diff_in + 8'd1) : diff_in;
        eff_off     = (thr_off < thr_on) ? thr_off : thr_on;
        over        = diff_valid && (mag >= thr_on);
        under       = diff_valid && (mag < eff_off);
        confirm_inc = confirm_q + 4'd1;
    end

    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                if (over) begin
                    confirm_d = 4'd1;
                    state_d   = (CONFIRM_N == 4'd1) ? ACTIVE : ARM;
                end
            end
            ARM: begin
                if (over) begin
                    if (confirm_inc == CONFIRM_N) begin
                        state_d   = ACTIVE;
                        confirm_d = 4'd0;
                    end else begin
                        confirm_d = confirm_inc;
                    end
                end else if (diff_valid) begin
                    state_d   = IDLE;
                    confirm_d = 4'd0;
                end
            end
            ACTIVE: begin
                if (under) begin
                    state_d = HOLD;
                    timer_d = HOLD_N;
                end
            end
            HOLD: begin
                // A non-under sample wins over expiry on the same clock.
                if (diff_valid && !under) begin
                    state_d = ACTIVE;
                    timer_d = 16'd0;
                end else if (timer_q <= 16'd1) begin
                    state_d = IDLE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                confirm_d = 4'd0;
                timer_d   = 16'd0;
            end
        endcase
    end

    always_comb begin
        onset_d   = ((state_q == IDLE) || (state_q == ARM)) && (state_d == ACTIVE);
        active_d  = (state_d == ACTIVE) || (state_d == HOLD);
        event_d   = event_q + {7'd0, onset_d};
        mag_out_d = diff_valid ? mag : mag_out_q;
        peak_d    = peak_q;
        if (peak_clr) begin
            peak_d = diff_valid ? mag : 8'd0;
        end else if (diff_valid && (mag > peak_q)) begin
            peak_d = mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            confirm_q   <= 4'd0;
            timer_q     <= 16'd0;
            mag_out_q   <= 8'd0;
            mag_valid_q <= 1'b0;
            active_q    <= 1'b0;
            onset_q     <= 1'b0;
            peak_q      <= 8'd0;
            event_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            confirm_q   <= confirm_d;
            timer_q     <= timer_d;
            mag_out_q   <= mag_out_d;
            mag_valid_q <= diff_valid;
            active_q    <= active_d;
            onset_q     <= onset_d;
            peak_q      <= peak_d;
            event_q     <= event_d;
        end
    end

    assign mag_out   = mag_out_q;
    assign mag_valid = mag_valid_q;
    assign active    = active_q;
    assign onset     = onset_q;
    assign peak      = peak_q;
    assign event_cnt = event_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_diff_motion_detect.sv
// Self-checking bench for diff_motion_detect: magnitude scoreboard plus directed
// confirm, hold, re-trigger, peak, reset and wrap scenarios.
module tb_diff_motion_detect;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [7:0] diff_in;
    logic       diff_valid;
    logic [7:0] thr_on;
    logic [7:0] thr_off;
    logic       peak_clr;
    logic [7:0] mag_out;
    logic       mag_valid;
    logic       active;
    logic       onset;
    logic [7:0] peak;
    logic [7:0] event_cnt;
    logic [1:0] state_o;

    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_err;

    diff_motion_detect #(.CONFIRM_CNT(3), .HOLD_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .diff_in    (diff_in),
        .diff_valid (diff_valid),
        .thr_on     (thr_on),
        .thr_off    (thr_off),
        .peak_clr   (peak_clr),
        .mag_out    (mag_out),
        .mag_valid  (mag_valid),
        .active     (active),
        .onset      (onset),
        .peak       (peak),
        .event_cnt  (event_cnt),
        .state_o    (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks: called on a falling edge, return on the falling edge after the sample
    task automatic send(input logic [7:0] d);
        logic [7:0] m;
        m          = d[7] ? (8'd0 - d) : d;
        diff_in    = d;
        diff_valid = 1'b1;
        exp_q.push_back(m);
        @(negedge clk);
        diff_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic episode();
        send(8'd25); send(8'd25); send(8'd25);
        send(8'd3);
        idle(8);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n && mag_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 16'(mag_out), 16'hFFFF);
            end else begin
                check("sb_mag", 16'(mag_out), 16'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        diff_in    = 8'd0;
        diff_valid = 1'b0;
        thr_on     = 8'd20;
        thr_off    = 8'd10;
        peak_clr   = 1'b0;
        #1;
        check("rst_mag", 16'(mag_out), 0);
        check("rst_active", 16'(active), 0);
        check("rst_event", 16'(event_cnt), 0);
        check("rst_state", 16'(state_o), 16'(S_IDLE));
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("release_mag_valid", 16'(mag_valid), 0);

        // magnitude
        send(8'h05); send(8'hFB); send(8'h80); send(8'h00);
        check("mag_idle_state", 16'(state_o), 16'(S_IDLE));
        idle(1);
        check("mag_valid_drop", 16'(mag_valid), 0);
        check("mag_hold", 16'(mag_out), 0);
        check("peak_128", 16'(peak), 128);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 19)));
        check("rand_small_no_arm", 16'(active), 0);

        // confirm
        send(8'h19); send(8'hE7);
        check("arm_no_onset", 16'(onset), 0);
        check("arm_inactive", 16'(active), 0);
        send(8'h1E);
        check("confirm_onset", 16'(onset), 1);
        check("confirm_active", 16'(active), 1);
        check("confirm_event", 16'(event_cnt), 1);
        idle(1);
        check("onset_pulse", 16'(onset), 0);

        // hold for exactly 8 clocks
        send(8'h03);
        check("hold_state", 16'(state_o), 16'(S_HOLD));
        check("hold_active_0", 16'(active), 1);
        for (int k = 1; k < 8; k++) begin
            idle(1);
            check("hold_active", 16'(active), 1);
        end
        idle(1);
        check("hold_release", 16'(active), 0);
        check("hold_idle", 16'(state_o), 16'(S_IDLE));

        // re-entry from HOLD via mag 15
        send(8'd25); send(8'd25); send(8'd25);
        check("event_2", 16'(event_cnt), 2);
        send(8'h03);
        idle(2);
        send(8'h0F);
        check("retrig_state", 16'(state_o), 16'(S_ACTIVE));
        check("retrig_onset", 16'(onset), 0);
        check("retrig_event", 16'(event_cnt), 2);
        idle(10);
        check("active_persist", 16'(active), 1);

        // aborted confirm returns to IDLE, next try starts over
        send(8'h03); idle(8);
        check("idle_again", 16'(active), 0);
        send(8'd25); send(8'd25); send(8'd5);
        check("abort_state", 16'(state_o), 16'(S_IDLE));
        check("abort_event", 16'(event_cnt), 2);
        send(8'd25); send(8'd25);
        check("rearm_no_onset", 16'(active), 0);
        send(8'd25);
        check("rearm_onset", 16'(onset), 1);
        check("event_3", 16'(event_cnt), 3);

        // peak clear and coincidence
        peak_clr = 1'b1; idle(1); peak_clr = 1'b0;
        check("peak_clr", 16'(peak), 0);
        send(8'd40);
        check("peak_40", 16'(peak), 40);
        peak_clr = 1'b1; send(8'hF4); peak_clr = 1'b0;
        check("peak_coincide", 16'(peak), 12);

        // re-trigger on the expiry clock
        send(8'd5);
        check("peak_keep", 16'(peak), 12);
        check("expiry_hold", 16'(state_o), 16'(S_HOLD));
        idle(7);
        send(8'd15);
        check("expiry_retrig", 16'(state_o), 16'(S_ACTIVE));
        idle(2);
        check("expiry_active", 16'(active), 1);
        check("expiry_event", 16'(event_cnt), 3);
        send(8'd5); idle(8);

        // asynchronous reset in HOLD
        episode(); episode(); episode();
        send(8'd90); send(8'd90); send(8'd90);
        send(8'd3);
        check("pre_rst_event", 16'(event_cnt), 7);
        check("pre_rst_peak", 16'(peak), 90);
        check("pre_rst_hold", 16'(state_o), 16'(S_HOLD));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_active", 16'(active), 0);
        check("arst_peak", 16'(peak), 0);
        check("arst_event", 16'(event_cnt), 0);
        check("arst_mag", 16'(mag_out), 0);
        check("arst_state", 16'(state_o), 16'(S_IDLE));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_onset", 16'(onset), 0);
        send(8'd25); send(8'd25);
        check("post_rst_arm", 16'(active), 0);
        send(8'd25);
        check("post_rst_onset", 16'(onset), 1);
        check("post_rst_event", 16'(event_cnt), 1);
        send(8'd3); idle(8);

        // wrap after 255 further onsets
        for (int e = 0; e < 255; e++) episode();
        check("event_wrap", 16'(event_cnt), 0);

        // thr_off above thr_on: release below thr_on
        thr_off = 8'd50;
        send(8'd25); send(8'd25); send(8'd25);
        check("wide_onset", 16'(event_cnt), 1);
        send(8'd30);
        check("wide_stay", 16'(state_o), 16'(S_ACTIVE));
        send(8'd19);
        check("wide_hold", 16'(state_o), 16'(S_HOLD));
        idle(2);
        check("sb_drain", 16'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
